// File: rtl/cpu_pkg.sv
// Shared opcode constants, sequencer state encoding and the instruction decoder
// for the 8-bit CPU control path.
package cpu_pkg;

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_ALU_LO = 8'h01;
  localparam logic [7:0] OPC_ALU_HI = 8'h0F;
  localparam logic [7:0] OPC_JMP    = 8'h10;
  localparam logic [7:0] OPC_JZ     = 8'h11;
  localparam logic [7:0] OPC_HALT   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_OP,
    S_F_A,
    S_F_B,
    S_CAPT,
    S_EXEC,
    S_WB,
    S_HALT
  } seq_state_t;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_ALU,
    OP_JMP,
    OP_JZ,
    OP_HALT,
    OP_ILLEGAL
  } op_class_t;

  function automatic op_class_t decode_op(input logic [7:0] opc);
    op_class_t cls;
    if (opc == OPC_NOP)                              cls = OP_NOP;
    else if (opc >= OPC_ALU_LO && opc <= OPC_ALU_HI) cls = OP_ALU;
    else if (opc == OPC_JMP)                         cls = OP_JMP;
    else if (opc == OPC_JZ)                          cls = OP_JZ;
    else if (opc == OPC_HALT)                        cls = OP_HALT;
    else                                             cls = OP_ILLEGAL;
    return cls;
  endfunction

endpackage

// File: rtl/fetch_exec_sequencer.sv
// Fetch/execute control FSM for the 8-bit CPU: fetches {opcode, op1, op2} from the
// single-port program RAM, pulses the data_path loads, owns the PC, and lends the RAM to the loader.
module fetch_exec_sequencer
  import cpu_pkg::*;
#(
  parameter int                  ADDR_W   = 8,
  parameter int                  DATA_W   = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flag_z,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] alu_op,
  output logic              reg_load_a,
  output logic              reg_load_b,
  output logic              reg_load_c,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  op_class_t         cls_q, cls_d;
  logic              zflag_q, zflag_d;
  logic              illegal_q, illegal_d;
  logic [ADDR_W-1:0] pc_plus3;

  assign pc_plus3 = pc_q + ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      cls_q     <= OP_NOP;
      zflag_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      cls_q     <= cls_d;
      zflag_q   <= zflag_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    cls_d      = cls_q;
    zflag_d    = zflag_q;
    illegal_d  = illegal_q;
    mem_addr   = pc_q;
    mem_we     = 1'b0;
    reg_load_a = 1'b0;
    reg_load_b = 1'b0;
    reg_load_c = 1'b0;
    alu_op     = '0;

    case (state_q)
      S_IDLE: begin
        mem_addr = load_addr;
        mem_we   = load_we;
        if (run) state_d = S_F_OP;
      end
      S_F_OP: begin
        state_d = S_F_A;
      end
      // RAM read data lags the address by one cycle, so each byte lands one state later.
      S_F_A: begin
        ir_d     = mem_rdata;
        mem_addr = pc_q + ADDR_W'(1);
        state_d  = S_F_B;
      end
      S_F_B: begin
        op1_d    = mem_rdata;
        mem_addr = pc_q + ADDR_W'(2);
        state_d  = S_CAPT;
      end
      S_CAPT: begin
        op2_d   = mem_rdata;
        cls_d   = decode_op(ir_q);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        zflag_d = flag_z;
        if (cls_q == OP_ALU) begin
          reg_load_a = 1'b1;
          reg_load_b = 1'b1;
          alu_op     = DATA_W'(ir_q[3:0]);
        end
        state_d = S_WB;
      end
      S_WB: begin
        if (cls_q == OP_ALU) begin
          reg_load_c = 1'b1;
          alu_op     = DATA_W'(ir_q[3:0]);
        end
        state_d = run ? S_F_OP : S_IDLE;
        case (cls_q)
          OP_NOP, OP_ALU: pc_d = pc_plus3;
          OP_JMP:         pc_d = ADDR_W'(op1_q);
          OP_JZ:          pc_d = zflag_q ? ADDR_W'(op1_q) : pc_plus3;
          OP_HALT:        state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_HALT: begin
        mem_addr = load_addr;
        mem_we   = load_we;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);
  assign load_err  = busy && load_we;
  assign mem_wdata = load_data;
  assign ir        = ir_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign pc        = pc_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Self-checking bench: table of single-instruction vectors, directed multi-cycle sequences,
// and random programs checked against an instruction-level reference model.
module tb_fetch_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       load_we = 1'b0;
  logic [7:0] load_addr = 8'h00;
  logic [7:0] load_data = 8'h00;
  logic       load_err;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       flag_z = 1'b0;
  logic [7:0] ir, op1, op2, alu_op, pc;
  logic       reg_load_a, reg_load_b, reg_load_c;
  logic       busy, halted, illegal;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram [256];
  logic [7:0] model_mem [256];
  logic [7:0] inj_addr, inj_data;

  fetch_exec_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .load_err(load_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .flag_z(flag_z), .ir(ir), .op1(op1), .op2(op2), .alu_op(alu_op),
    .reg_load_a(reg_load_a), .reg_load_b(reg_load_b), .reg_load_c(reg_load_c),
    .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Program RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; load_we = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    load_addr = a; load_data = d; load_we = 1'b1;
    step();
    load_we = 1'b0;
    model_mem[a] = d;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    case ($urandom_range(7))
      0:       b = 8'h00;
      1, 2:    b = 8'($urandom_range(15, 1));
      3:       b = 8'h10;
      4:       b = 8'h11;
      5:       b = ($urandom_range(3) == 0) ? 8'hFF : 8'h00;
      default: b = 8'($urandom);
    endcase
    return b;
  endfunction

  task automatic fill_all(input bit randomize_it);
    for (int a = 0; a < 256; a++) load_byte(8'(a), randomize_it ? rand_byte() : 8'h00);
  endtask

  // Instruction-level reference: what one instruction at pc does.
  function automatic void model_exec(input logic [7:0] mpc, input bit fz,
                                     output logic [7:0] m_ir, output logic [7:0] m_op1,
                                     output logic [7:0] m_op2, output logic [7:0] m_npc,
                                     output bit m_alu, output bit m_halt, output bit m_ill);
    logic [7:0] p1, p2, p3;
    p1 = mpc + 8'd1; p2 = mpc + 8'd2; p3 = mpc + 8'd3;
    m_ir = model_mem[mpc]; m_op1 = model_mem[p1]; m_op2 = model_mem[p2];
    m_alu = 0; m_halt = 0; m_ill = 0; m_npc = p3;
    if (m_ir == 8'h00) m_npc = p3;
    else if (m_ir <= 8'h0F) m_alu = 1;
    else if (m_ir == 8'h10) m_npc = m_op1;
    else if (m_ir == 8'h11) m_npc = fz ? m_op1 : p3;
    else begin
      m_halt = 1; m_npc = mpc;
      m_ill = (m_ir != 8'hFF);
    end
  endfunction

  // Entered in the F_OP cycle; leaves in the cycle after WB.
  task automatic do_instr(input logic [7:0] e_pc, input logic [7:0] e_ir,
                          input logic [7:0] e_op1, input logic [7:0] e_op2,
                          input bit e_alu, input bit e_halt, input bit e_ill,
                          input logic [7:0] e_npc, input bit fz, input bit keep, input bit inj);
    logic [7:0] a0, a1, a2, p1, p2, e_aop;
    p1 = e_pc + 8'd1; p2 = e_pc + 8'd2;
    e_aop = e_alu ? {4'h0, e_ir[3:0]} : 8'h00;
    flag_z = fz;
    a0 = mem_addr;
    chk1("busy_fop", busy, 1'b1);
    step();
    a1 = mem_addr;
    if (!keep) run = 1'b0;
    step();
    a2 = mem_addr;
    if (inj) begin
      load_addr = inj_addr; load_data = inj_data; load_we = 1'b1;
      #1;
      chk1("load_err_busy", load_err, 1'b1);
      chk1("mem_we_busy", mem_we, 1'b0);
    end else begin
      chk1("load_err_quiet", load_err, 1'b0);
    end
    chk8("fetch_addr0", a0, e_pc);
    chk8("fetch_addr1", a1, p1);
    chk8("fetch_addr2", a2, p2);
    step();
    load_we = 1'b0;
    chk8("ir_capt", ir, e_ir);
    chk8("op1_capt", op1, e_op1);
    chk1("load_a_capt", reg_load_a, 1'b0);
    step();
    chk8("op2_exec", op2, e_op2);
    chk1("load_a_exec", reg_load_a, e_alu);
    chk1("load_b_exec", reg_load_b, e_alu);
    chk1("load_c_exec", reg_load_c, 1'b0);
    chk8("alu_op_exec", alu_op, e_aop);
    step();
    chk1("load_c_wb", reg_load_c, e_alu);
    chk1("load_a_wb", reg_load_a, 1'b0);
    chk8("alu_op_wb", alu_op, e_aop);
    chk8("pc_wb", pc, e_pc);
    step();
    chk8("pc_next", pc, e_npc);
    chk1("halted_next", halted, e_halt);
    chk1("illegal_next", illegal, e_halt && e_ill);
    chk1("busy_next", busy, !e_halt && keep);
    chk1("load_c_next", reg_load_c, 1'b0);
  endtask

  // Runs from pc=RESET_PC in IDLE for up to max_n instructions.
  task automatic run_program(input int max_n, input bit rand_inj, input bit first_inj);
    logic [7:0] mpc, m_ir, m_op1, m_op2, m_npc;
    bit m_alu, m_halt, m_ill, fz, keep, inj;
    int n;
    mpc = 8'h00; m_halt = 0;
    run = 1'b1;
    step();
    for (n = 0; n < max_n; n++) begin
      fz = 1'($urandom);
      model_exec(mpc, fz, m_ir, m_op1, m_op2, m_npc, m_alu, m_halt, m_ill);
      keep = (n < max_n - 1);
      inj = (n == 0 && first_inj) || (rand_inj && $urandom_range(3) == 0);
      if (rand_inj) begin
        inj_addr = 8'($urandom); inj_data = 8'($urandom);
      end
      do_instr(mpc, m_ir, m_op1, m_op2, m_alu, m_halt, m_ill, m_npc, fz, keep, inj);
      mpc = m_npc;
      if (m_halt || !keep) break;
    end
    if (m_halt) begin
      run = 1'b1;
      step(); step();
      load_addr = 8'($urandom);
      #1;
      chk1("halt_sticky", halted, 1'b1);
      chk1("halt_not_busy", busy, 1'b0);
      chk8("halt_pc", pc, mpc);
      chk8("halt_loader_addr", mem_addr, load_addr);
      run = 1'b0;
    end
    $display("program: %0d instr, final pc=%02h halted=%0b illegal=%0b", n + 1, pc, halted, illegal);
  endtask

  typedef struct {
    logic [7:0] opc, o1, o2;
    bit         fz;
    logic [7:0] npc;
    bit         alu, halt, ill;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0] m_ir, m_op1, m_op2, m_npc;
    bit m_alu, m_halt, m_ill;

    tbl[0] = '{8'h03, 8'h05, 8'h07, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h12, 8'h34, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'h10, 8'h09, 8'h00, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h11, 8'h20, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h11, 8'h20, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h42, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h0F, 8'hAA, 8'h55, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{8'h12, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{8'h10, 8'hFD, 8'h01, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0};
    inj_addr = 8'h00; inj_data = 8'h00;

    do_reset();
    chk8("rst_pc", pc, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chk8("rst_ir", ir, 8'h00);
    chk8("rst_alu_op", alu_op, 8'h00);
    chk1("rst_load_c", reg_load_c, 1'b0);
    chk1("rst_load_err", load_err, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    fill_all(0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      load_byte(8'h00, tbl[i].opc);
      load_byte(8'h01, tbl[i].o1);
      load_byte(8'h02, tbl[i].o2);
      run = 1'b1;
      step();
      do_instr(8'h00, tbl[i].opc, tbl[i].o1, tbl[i].o2, tbl[i].alu, tbl[i].halt,
               tbl[i].ill, tbl[i].npc, tbl[i].fz, 1'b0, 1'b0);
      $display("vector %0d: opcode %02h -> pc=%02h halted=%0b illegal=%0b",
               i, tbl[i].opc, pc, halted, illegal);
    end

    // ALU then HALT with run held high.
    do_reset();
    load_byte(8'h00, 8'h03); load_byte(8'h01, 8'h05); load_byte(8'h02, 8'h07);
    load_byte(8'h03, 8'hFF); load_byte(8'h04, 8'h00); load_byte(8'h05, 8'h00);
    run_program(4, 1'b0, 1'b0);

    // Loader write during F_B is dropped: HALT at 3 must survive.
    do_reset();
    inj_addr = 8'h03; inj_data = 8'h00;
    run_program(4, 1'b0, 1'b1);

    // JMP to 9, HALT at 9.
    do_reset();
    load_byte(8'h00, 8'h10); load_byte(8'h01, 8'h09); load_byte(8'h02, 8'h00);
    load_byte(8'h09, 8'hFF);
    run_program(4, 1'b0, 1'b0);

    // Wrap: JMP FE, NOP at FE fetches FE,FF,00, then illegal FE at pc 01.
    do_reset();
    load_byte(8'h01, 8'hFE); load_byte(8'h00, 8'h10); load_byte(8'h02, 8'h00);
    load_byte(8'hFE, 8'h00); load_byte(8'hFF, 8'h00);
    run_program(5, 1'b0, 1'b0);

    // Reset during EXEC aborts without writeback.
    do_reset();
    load_byte(8'h00, 8'h00); load_byte(8'h01, 8'h00); load_byte(8'h02, 8'h00);
    load_byte(8'h03, 8'h03); load_byte(8'h04, 8'h05); load_byte(8'h05, 8'h07);
    run = 1'b1;
    step();
    model_exec(8'h00, 1'b0, m_ir, m_op1, m_op2, m_npc, m_alu, m_halt, m_ill);
    do_instr(8'h00, m_ir, m_op1, m_op2, m_alu, m_halt, m_ill, m_npc, 1'b0, 1'b1, 1'b0);
    step(); step(); step(); step();
    chk1("exec_before_rst", reg_load_a, 1'b1);
    rst = 1'b1; run = 1'b0;
    step();
    rst = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_load_c", reg_load_c, 1'b0);
    chk8("abort_pc", pc, 8'h00);
    chk1("abort_halted", halted, 1'b0);
    load_addr = 8'h5A;
    #1;
    chk8("idle_loader_addr", mem_addr, 8'h5A);
    $display("reset-in-EXEC sequence: pc=%02h busy=%0b", pc, busy);

    for (int p = 0; p < 10; p++) begin
      fill_all(1);
      do_reset();
      run_program(20, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
